// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the 8 bus requesters and the Mux8 round-robin arbiter.
// The arbiter is the slave side: it samples req and returns a registered grant and mux select.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       preempt;

  modport master (
    output req,
    input  grant,
    input  sel,
    input  valid,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output sel,
    output valid,
    output preempt
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of the shared 8-input datapath mux with bounded hold time.
// All outputs come straight from flops; req only reaches next-state logic.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux8_rr_arbiter_if.slave     bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state_q,   state_d;
  logic [7:0] grant_q,   grant_d;
  logic [2:0] sel_q,     sel_d;
  logic [2:0] last_q,    last_d;
  logic       valid_q,   valid_d;
  logic       preempt_q, preempt_d;
  logic [7:0] hold_q,    hold_d;

  logic [7:0]  others;
  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  pick_off;
  logic [2:0]  win;
  logic        found;
  logic        owner_req;

  // Candidates never include the current owner, so the same search serves
  // release, expiry and the idle case (grant_q is zero there).
  assign others    = bus.req & ~grant_q;
  assign owner_req = |(bus.req & grant_q);
  assign found     = |others;

  // Rotate so bit 0 of rot is index last+1; the 3-bit add wraps 7->0.
  always_comb begin
    dbl = {others, others} >> (last_q + 3'd1);
    rot = dbl[7:0];
  end

  always_comb begin
    logic hit;
    hit      = 1'b0;
    pick_off = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (rot[k] && !hit) begin
        pick_off = 3'(k);
        hit      = 1'b1;
      end
    end
  end

  assign win = last_q + 3'd1 + pick_off;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          grant_d = 8'b1 << win;
          sel_d   = win;
          last_d  = win;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      OWNED: begin
        // Release is tested before expiry so a simultaneous drop never pulses preempt.
        if (!owner_req) begin
          if (found) begin
            grant_d = 8'b1 << win;
            sel_d   = win;
            last_d  = win;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (HOLD_EN && hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (found) begin
            grant_d   = 8'b1 << win;
            sel_d     = win;
            last_d    = win;
            preempt_d = 1'b1;
          end
        end else if (HOLD_EN) begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      last_q    <= 3'd7;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.valid   = valid_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter (MAX_HOLD=4): directed scenarios plus random requests
// compared against an owner/queue reference model.
module tb_mux8_rr_arbiter;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns, for how many visible cycles, and the rotation origin.
  int m_owner;
  int m_last;
  int m_held;
  int m_sel;
  bit m_pre;

  function automatic int rr_next(logic [7:0] r, int after, int skip);
    int order[$];
    for (int k = 1; k <= 8; k++) order.push_back((after + k) % 8);
    foreach (order[j]) if (order[j] != skip && r[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [7:0] m_grant();
    logic [7:0] g;
    g = 8'h00;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 7; m_held = 0; m_sel = 0; m_pre = 1'b0;
  endtask

  task automatic model_take(int w);
    m_owner = w; m_last = w; m_sel = w; m_held = 1;
  endtask

  task automatic model_step(logic [7:0] r);
    int w;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      w = rr_next(r, m_last, -1);
      if (w >= 0) model_take(w);
    end else if (!r[m_owner]) begin
      w = rr_next(r, m_last, m_owner);
      if (w >= 0) model_take(w);
      else m_owner = -1;
    end else if (MH != 0 && m_held == MH) begin
      w = rr_next(r, m_last, m_owner);
      if (w >= 0) begin
        model_take(w);
        m_pre = 1'b1;
      end else begin
        m_held = 1;
      end
    end else begin
      m_held++;
    end
  endtask

  // Starts and ends at posedge+1.
  task automatic tick(logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 8'hFF;
    #3;
    checks++; if (bus.grant !== 8'h00) begin errors++; $display("FAIL reset_grant got %h exp 00", bus.grant); end
    checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", bus.sel); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
    checks++; if (bus.preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt got %b exp 0", bus.preempt); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    tick(8'h04);
    checks++; if (bus.grant !== 8'h04) begin errors++; $display("FAIL single_grant got %h exp 04", bus.grant); end
    checks++; if (bus.sel !== 3'd2) begin errors++; $display("FAIL single_sel got %0d exp 2", bus.sel); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.valid); end
    tick(8'h00);
    checks++; if (bus.grant !== 8'h00) begin errors++; $display("FAIL drop_grant got %h exp 00", bus.grant); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b exp 0", bus.valid); end
    checks++; if (bus.sel !== 3'd2) begin errors++; $display("FAIL drop_sel_hold got %0d exp 2", bus.sel); end
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    do_reset();
    tick(8'hFF);
    for (int n = 0; n <= 8; n++) begin
      e = 8'h00;
      e[n % 8] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (bus.grant !== e || bus.valid !== 1'b1) begin
          errors++; $display("FAIL rr_order step %0d cyc %0d got %h/%b exp %h/1", n, c, bus.grant, bus.valid, e);
        end
        if (c < 2) tick(8'hFF);
      end
      tick(8'hFF & ~e);
    end
  endtask

  task automatic test_preempt();
    int pulses;
    do_reset();
    tick(8'h20);
    tick(8'h20);
    tick(8'h22);
    tick(8'h22);
    checks++; if (bus.grant !== 8'h20 || bus.preempt !== 1'b0) begin errors++; $display("FAIL pre_hold got %h/%b exp 20/0", bus.grant, bus.preempt); end
    tick(8'h22);
    checks++; if (bus.grant !== 8'h02) begin errors++; $display("FAIL pre_move got %h exp 02", bus.grant); end
    checks++; if (bus.preempt !== 1'b1) begin errors++; $display("FAIL pre_pulse got %b exp 1", bus.preempt); end
    pulses = 0;
    tick(8'h22);
    if (bus.preempt === 1'b1) pulses++;
    tick(8'h22);
    if (bus.preempt === 1'b1) pulses++;
    checks++; if (pulses != 0) begin errors++; $display("FAIL pre_one_cycle extra_pulses %0d exp 0", pulses); end
    tick(8'h20);
    checks++; if (bus.grant !== 8'h20 || bus.sel !== 3'd5) begin errors++; $display("FAIL pre_return got %h/%0d exp 20/5", bus.grant, bus.sel); end
  endtask

  task automatic test_no_other();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick(8'h08);
      if (bus.grant !== 8'h08 || bus.preempt !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL sole_owner bad_cycles %0d exp 0", bad); end
  endtask

  task automatic test_release_at_expiry();
    do_reset();
    tick(8'h40);
    tick(8'h41);
    tick(8'h41);
    tick(8'h41);
    checks++; if (bus.grant !== 8'h40) begin errors++; $display("FAIL rel_exp_hold got %h exp 40", bus.grant); end
    tick(8'h01);
    checks++; if (bus.grant !== 8'h01 || bus.sel !== 3'd0) begin errors++; $display("FAIL rel_exp_wrap got %h/%0d exp 01/0", bus.grant, bus.sel); end
    checks++; if (bus.preempt !== 1'b0) begin errors++; $display("FAIL rel_exp_preempt got %b exp 0", bus.preempt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(8'h10);
    tick(8'h10);
    checks++; if (bus.grant !== 8'h10) begin errors++; $display("FAIL ar_own got %h exp 10", bus.grant); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.grant !== 8'h00 || bus.valid !== 1'b0) begin errors++; $display("FAIL ar_clear got %h/%b exp 00/0", bus.grant, bus.valid); end
    checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL ar_sel got %0d exp 0", bus.sel); end
    model_reset();
    bus.req = 8'h11;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(8'h11);
    #1;
    checks++; if (bus.grant !== 8'h01 || bus.sel !== 3'd0) begin errors++; $display("FAIL ar_first got %h/%0d exp 01/0", bus.grant, bus.sel); end
    tick(8'h00);
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] g;
    do_reset();
    r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      tick(r);
      g = m_grant();
      checks++;
      if (bus.grant !== g || bus.sel !== 3'(m_sel) || bus.valid !== (m_owner >= 0) || bus.preempt !== m_pre) begin
        errors++;
        $display("FAIL rand cyc %0d req %h got g=%h s=%0d v=%b p=%b exp g=%h s=%0d v=%b p=%b",
                 c, r, bus.grant, bus.sel, bus.valid, bus.preempt, g, m_sel, (m_owner >= 0), m_pre);
      end
      checks++;
      if ($countones(bus.grant) > 1 || bus.valid !== (|bus.grant) ||
          (bus.valid && bus.grant !== (8'h01 << bus.sel))) begin
        errors++; $display("FAIL invariant cyc %0d got g=%h s=%0d v=%b", c, bus.grant, bus.sel, bus.valid);
      end
    end
  endtask

  initial begin
    bus.req = 8'h00;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_no_other();
    test_release_at_expiry();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-input datapath mux (Mux8 select convention: sel=i routes input a[i]) among 8 requesters on the stack CPU internal bus.
- Registers the grant, drives the 3-bit mux select and a one-hot grant vector.
- Enforces a bounded hold time so no requester can starve the others.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant while others are waiting; 0 disables preemption. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector; req[i] is level-sensitive and held until requester i is done
- grant  output  8  one-hot grant, registered; all-zero when no owner
- sel  output  3  binary index of current owner; drives Mux8 sel[2:0]
- valid  output  1  1 when grant is non-zero (sel meaningful)
- preempt  output  1  one-cycle pulse on the cycle the grant is taken from an owner still requesting

Behaviour:
- Reset (async assert, sync release): grant=0, sel=0, valid=0, preempt=0, state=IDLE, hold_cnt=0, last=7. With last=7, the first search starts at index 0.
- Round-robin search: scan indices (last+1) mod 8, (last+2) mod 8, ... wrapping through 7→0, and pick the first i with req[i]=1.
- Each new grant updates last=i and clears hold_cnt to 0.
- States: IDLE, OWNED.
- IDLE, req==0: stay; all outputs 0 except sel, which holds its last value.
- IDLE, req!=0: on the next rising edge go to OWNED. grant=1<<i, sel=i, valid=1. Latency from req sampled high to grant visible is exactly 1 cycle.
- OWNED, owner's req[sel] sampled 0 (release):
  - if any other req bit is set, grant moves to the round-robin winner on that same edge, with no dead cycle;
  - otherwise go to IDLE: grant=0, valid=0.
- OWNED, owner still requesting, MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1:
  - if any other req bit is set, re-arbitrate excluding the owner; grant moves to the winner and preempt=1 for one cycle;
  - if no other request, owner keeps the grant and hold_cnt wraps to 0; preempt stays 0.
- OWNED otherwise: hold_cnt increments by 1 each cycle and grant is unchanged.
- MAX_HOLD=0: hold_cnt is frozen at 0 and preemption never occurs.
- Simultaneous release and expiry: the release rule takes precedence and preempt stays 0.
- The round-robin pointer advances only on a grant; requests arriving mid-ownership never disturb the current owner before release or expiry.
- Invariants, every cycle:
  - grant is one-hot or zero;
  - valid == |grant;
  - when valid=1, grant == 1<<sel.
- Async reset asserted mid-ownership clears all state immediately, independent of clk. After release, the next grant starts from index 0.
- All outputs are driven from flops; there is no combinational path from req to any output.
- Expected size: ~150-250 lines of RTL (priority rotate/encode, hold counter, 2-state FSM).

Test Plan:
- Reset, then req=8'b0000_0100 → one cycle later grant=8'h04, sel=2, valid=1. Drop req → next cycle grant=0, valid=0, sel stays 2.
- After reset, req=8'hFF held with each owner releasing after 3 cycles → grant order 0,1,2,...,7,0. Every transition happens without an idle cycle between grants.
- MAX_HOLD=4, req[5] held permanently, req[1] raised at cycle 2 of ownership → grant moves to index 1 after the 4th owned cycle, preempt=1 for exactly one cycle. After req[1] releases, grant returns to 5.
- MAX_HOLD=4, only req[3] held for 20 cycles → grant stays 8'h08 throughout, preempt never asserts.
- Owner 6 drops req on the same cycle its hold expires, with req[0] pending → grant=8'h01, preempt=0. Wrap from 6 to 0 is correct.
- Assert rst_n=0 mid-ownership of index 4, asynchronous to clk → grant=0, valid=0 immediately. Release with req=8'h11 → first grant goes to index 0.
